// File: rtl/f1_pkg.sv
// ---------------------------------------------------------------------------
// f1_pkg
// Definitions shared by the F1 start-light random delay block: FSM state
// type, default generator width, and the LFSR seed and feedback tap.
// ---------------------------------------------------------------------------
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    localparam int unsigned LFSR_W_DEF = 7;

    // Non-zero seed keeps the maximal-length sequence away from the lock-up state
    localparam logic [6:0]  LFSR_SEED  = 7'b0000001;

    // Feedback is q[W-1] ^ q[LFSR_TAP]  (x^7 + x^3 + 1 for W = 7)
    localparam int unsigned LFSR_TAP   = 2;

endpackage

// File: rtl/f1_delay_lfsr7.sv
// ---------------------------------------------------------------------------
// lfsr7
// Free-running Fibonacci LFSR supplying the pseudorandom delay value.
// It advances on every clock edge, whatever the delay FSM is doing.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (loads the seed)
//   q      out  current LFSR state, never zero
// ---------------------------------------------------------------------------
module lfsr7
    import f1_pkg::*;
#(
    parameter int unsigned W = LFSR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= W'(LFSR_SEED);
        end else begin
            q <= {q[W-2:0], q[W-1] ^ q[LFSR_TAP]};
        end
    end

endmodule

// File: rtl/f1_delay.sv
// ---------------------------------------------------------------------------
// f1_delay
// Random reaction-time delay for the F1 start lights. A trigger in IDLE
// captures K (1..127) from the LFSR, waits K units of (n+1) clocks, then
// pulses time_out for one cycle before returning to IDLE.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   trigger   in   start request, honoured only in IDLE
//   clear     in   synchronous abort back to IDLE, no time_out
//   n         in   clocks per delay unit minus one
//   time_out  out  one-cycle pulse when the delay expires
//   busy      out  high in COUNT and DONE
//   k_val     out  K captured at the last start
// ---------------------------------------------------------------------------
module f1_delay
    import f1_pkg::*;
#(
    parameter int unsigned LFSR_W = LFSR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic              clear,
    input  logic [15:0]       n,
    output logic              time_out,
    output logic              busy,
    output logic [LFSR_W-1:0] k_val
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LFSR_W-1:0]   w_lfsr_q;
    logic [LFSR_W-1:0]   r_unit;
    logic [LFSR_W-1:0]   w_unit_nxt;
    logic [15:0]         r_presc;
    logic [15:0]         w_presc_nxt;
    logic [LFSR_W-1:0]   r_k;
    logic [LFSR_W-1:0]   w_k_nxt;

    lfsr7 #(
        .W (LFSR_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_unit  <= '0;
            r_presc <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_unit  <= w_unit_nxt;
            r_presc <= w_presc_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_unit_nxt  = r_unit;
        w_presc_nxt = r_presc;
        w_k_nxt     = r_k;

        if (clear) begin
            // Abort from any state; k_val is deliberately kept
            w_state_nxt = IDLE;
            w_unit_nxt  = '0;
            w_presc_nxt = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (trigger) begin
                        w_k_nxt     = w_lfsr_q;
                        w_unit_nxt  = w_lfsr_q;
                        w_presc_nxt = n;
                        w_state_nxt = COUNT;
                    end
                end
                COUNT: begin
                    if (r_presc == '0) begin
                        // End of a unit: n is re-sampled only here
                        w_presc_nxt = n;
                        w_unit_nxt  = r_unit - LFSR_W'(1);
                        if (r_unit == LFSR_W'(1)) begin
                            w_state_nxt = DONE;
                        end
                    end else begin
                        w_presc_nxt = r_presc - 16'd1;
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign time_out = (r_state == DONE);
    assign busy     = (r_state != IDLE);
    assign k_val    = r_k;

endmodule

// File: tb/tb_f1_delay.sv
// ---------------------------------------------------------------------------
// tb_f1_delay
// Self-checking bench for f1_delay: directed timelines in vector tables,
// a mid-delay reset sequence, and a randomized run against a deadline-based
// reference model of the delay behaviour.
// ---------------------------------------------------------------------------
module tb_f1_delay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        trigger = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] n = '0;
    logic        time_out;
    logic        busy;
    logic [6:0]  k_val;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;

    typedef struct {
        logic        trig;
        logic        clr;
        logic [15:0] nv;
        logic        busy;
        logic        to;
        logic [6:0]  k;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    f1_delay #(
        .LFSR_W (7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trigger  (trigger),
        .clear    (clear),
        .n        (n),
        .time_out (time_out),
        .busy     (busy),
        .k_val    (k_val)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ecount++;
        #1;
    endtask

    task automatic do_reset();
        trigger = 1'b0;
        clear   = 1'b0;
        n       = '0;
        #1;
        rst_n = 1'b0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_to", time_out, 0);
        chk("reset_k", k_val, 0);
        chk("reset_lfsr", dut.u_lfsr.q, 1);
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;
    endtask

    function automatic void addv(input logic t, input logic c, input int nv,
                                 input logic b, input logic o, input int k);
        vec_t v;
        v.trig = t;
        v.clr  = c;
        v.nv   = 16'(nv);
        v.busy = b;
        v.to   = o;
        v.k    = 7'(k);
        vecs.push_back(v);
    endfunction

    // Row i is driven before edge i+1 and its outputs checked just after it
    task automatic run_vecs(input string name);
        do_reset();
        foreach (vecs[i]) begin
            trigger = vecs[i].trig;
            clear   = vecs[i].clr;
            n       = vecs[i].nv;
            step();
            chk($sformatf("%s_busy_e%0d", name, ecount), busy, vecs[i].busy);
            chk($sformatf("%s_to_e%0d", name, ecount), time_out, vecs[i].to);
            chk($sformatf("%s_k_e%0d", name, ecount), k_val, vecs[i].k);
        end
        vecs.delete();
        trigger = 1'b0;
        clear   = 1'b0;
    endtask

    initial begin : main
        logic [6:0] lfsr_exp [8];
        logic [6:0] m_lfsr;
        logic [6:0] m_k;
        bit         m_valid;
        int         m_dead;
        bit         idle;
        bit         m_busy;
        bit         hold;
        bit         seen_to;

        // LFSR sequence seen before edges 1..8 after reset
        lfsr_exp = '{7'd1, 7'd2, 7'd4, 7'd9, 7'd18, 7'd36, 7'd73, 7'd19};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lfsr_e%0d", i + 1), dut.u_lfsr.q, lfsr_exp[i]);
            step();
        end

        // n=0, trigger at edge 4: K=9, done after edge 13
        for (int e = 1; e <= 16; e++)
            addv(e == 4, 0, 0, e >= 4 && e <= 13, e == 13, (e >= 4) ? 9 : 0);
        run_vecs("n0");

        // n=2: done after edge 4 + 9*3 = 31
        for (int e = 1; e <= 34; e++)
            addv(e == 4, 0, 2, e >= 4 && e <= 31, e == 31, (e >= 4) ? 9 : 0);
        run_vecs("n2");

        // second trigger while counting is ignored
        for (int e = 1; e <= 20; e++)
            addv(e == 4 || e == 8, 0, 0, e >= 4 && e <= 13, e == 13, (e >= 4) ? 9 : 0);
        run_vecs("retrig");

        // clear at edge 9 aborts; k_val kept
        for (int e = 1; e <= 20; e++)
            addv(e == 4, e == 9, 0, e >= 4 && e <= 8, 0, (e >= 4) ? 9 : 0);
        run_vecs("clear");

        // clear and trigger together in IDLE: no start
        for (int e = 1; e <= 8; e++)
            addv(e == 4, e == 4, 0, 0, 0, 0);
        run_vecs("clrtrig");

        // n=1 at capture, n=0 afterwards: first unit 2 clocks, rest 1 -> done at 4+2+8=14
        for (int e = 1; e <= 18; e++)
            addv(e == 4, 0, (e == 4) ? 1 : 0, e >= 4 && e <= 14, e == 14, (e >= 4) ? 9 : 0);
        run_vecs("nchg");

        // reset asserted mid-COUNT aborts immediately
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            trigger = (e == 4);
            step();
        end
        trigger = 1'b0;
        chk("midrst_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_to", time_out, 0);
        chk("midrst_k", k_val, 0);
        chk("midrst_lfsr", dut.u_lfsr.q, 1);
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;
        chk("midrst_lfsr_hold", dut.u_lfsr.q, 1);
        step();
        chk("midrst_lfsr_first", dut.u_lfsr.q, 2);
        seen_to = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (time_out) seen_to = 1'b1;
        end
        chk("midrst_no_to", seen_to, 0);
        chk("midrst_idle", busy, 0);

        // randomized run against deadline model
        do_reset();
        m_lfsr  = 7'd1;
        m_k     = '0;
        m_valid = 1'b0;
        m_dead  = 0;
        m_busy  = 1'b0;
        hold    = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (c % 500 == 0) hold = ~hold;
            trigger = hold ? 1'b1 : ($urandom_range(0, 99) < 30);
            clear   = ($urandom_range(0, 63) == 0);
            if (!m_busy && $urandom_range(0, 7) == 0)
                n = 16'($urandom_range(0, 3));
            step();
            idle = !(m_valid && (ecount - 1) <= m_dead);
            if (clear) begin
                m_valid = 1'b0;
            end else if (idle && trigger) begin
                m_k     = m_lfsr;
                m_dead  = ecount + int'(m_k) * (int'(n) + 1);
                m_valid = 1'b1;
            end
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
            m_busy = m_valid && ecount <= m_dead;
            chk($sformatf("rnd_busy_e%0d", ecount), busy, m_busy);
            chk($sformatf("rnd_to_e%0d", ecount), time_out, m_valid && ecount == m_dead);
            chk($sformatf("rnd_k_e%0d", ecount), k_val, m_k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
